// File: rtl/key_debounce_pkg.sv
// Shared types for the key debounce bank: channel FSM states and event-type codes.
// KEY_DEBOUNCE_LONG_PRESS_EN (in the channel) enables the long-press event code.
package key_debounce_pkg;

    typedef enum logic [1:0] {
        StReleased    = 2'd0,
        StPressPend   = 2'd1,
        StPressed     = 2'd2,
        StReleasePend = 2'd3
    } key_fsm_e;

    typedef logic [1:0] evt_type_t;

    localparam evt_type_t EvtPress   = 2'b00;
    localparam evt_type_t EvtRelease = 2'b01;
    localparam evt_type_t EvtLong    = 2'b10;

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-flop synchronizer, debounce FSM and a one-deep pending event slot.
// Define KEY_DEBOUNCE_LONG_PRESS_EN to add the saturating long-press counter.
module key_debounce_ch import key_debounce_pkg::*; #(
    parameter int unsigned DebTicks  = 4,
    parameter int unsigned LongTicks = 100
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  logic      key_i,
    input  logic      tick_i,
    input  logic      drain_i,
    output logic      pend_valid_o,
    output evt_type_t pend_type_o,
    output logic      level_o,
    output logic      drop_o
);

    localparam logic [7:0] DebLast = 8'(DebTicks - 1);

    logic       s1_q, s_q;
    key_fsm_e   state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       press_done, release_done;
    logic       raise;
    evt_type_t  raise_type;
    logic       pend_valid_q, pend_valid_d;
    evt_type_t  pend_type_q, pend_type_d;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        press_done   = 1'b0;
        release_done = 1'b0;
        unique case (state_q)
            StReleased: begin
                if (tick_i && s_q) begin
                    if (DebTicks == 1) begin
                        state_d    = StPressed;
                        press_done = 1'b1;
                    end else begin
                        state_d = StPressPend;
                        cnt_d   = 8'd1;
                    end
                end
            end
            StPressPend: begin
                if (!s_q) begin
                    state_d = StReleased;
                    cnt_d   = '0;
                end else if (tick_i) begin
                    if (cnt_q == DebLast) begin
                        state_d    = StPressed;
                        cnt_d      = '0;
                        press_done = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            StPressed: begin
                if (tick_i && !s_q) begin
                    if (DebTicks == 1) begin
                        state_d      = StReleased;
                        release_done = 1'b1;
                    end else begin
                        state_d = StReleasePend;
                        cnt_d   = 8'd1;
                    end
                end
            end
            StReleasePend: begin
                if (s_q) begin
                    state_d = StPressed;
                    cnt_d   = '0;
                end else if (tick_i) begin
                    if (cnt_q == DebLast) begin
                        state_d      = StReleased;
                        cnt_d        = '0;
                        release_done = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            default: state_d = StReleased;
        endcase
    end

`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
    localparam logic [7:0] LongLim = 8'(LongTicks);

    logic [7:0] long_q, long_d;
    logic       long_fire;

    // Bouncing back from RELEASE_PEND is the same press, so only a real press clears the count;
    // a release completing on this tick takes priority over a coincident long-press.
    always_comb begin
        long_d    = long_q;
        long_fire = 1'b0;
        if (press_done) begin
            long_d = '0;
        end else if (tick_i && level_o && !release_done) begin
            if (long_q != 8'hff) begin
                long_d = long_q + 8'd1;
            end
            long_fire = (long_q != LongLim) && (long_d == LongLim);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            long_q <= '0;
        end else begin
            long_q <= long_d;
        end
    end

    assign raise      = press_done | release_done | long_fire;
    assign raise_type = release_done ? EvtRelease : (long_fire ? EvtLong : EvtPress);
`else
    assign raise      = press_done | release_done;
    assign raise_type = release_done ? EvtRelease : EvtPress;
`endif

    // A drain in the same cycle frees the slot, so a refill is kept rather than dropped.
    always_comb begin
        pend_valid_d = pend_valid_q;
        pend_type_d  = pend_type_q;
        drop_o       = 1'b0;
        if (drain_i) begin
            pend_valid_d = 1'b0;
        end
        if (raise) begin
            if (!pend_valid_q || drain_i) begin
                pend_valid_d = 1'b1;
                pend_type_d  = raise_type;
            end else begin
                drop_o = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q         <= 1'b0;
            s_q          <= 1'b0;
            state_q      <= StReleased;
            cnt_q        <= '0;
            pend_valid_q <= 1'b0;
            pend_type_q  <= EvtPress;
        end else begin
            s1_q         <= key_i;
            s_q          <= s1_q;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pend_valid_q <= pend_valid_d;
            pend_type_q  <= pend_type_d;
        end
    end

    assign level_o      = (state_q == StPressed) || (state_q == StReleasePend);
    assign pend_valid_o = pend_valid_q;
    assign pend_type_o  = pend_type_q;

endmodule

// File: rtl/key_debounce_bank.sv
// Bank of debounced keys with a lowest-index-first valid/ready event stream and sticky overflow.
// KEY_DEBOUNCE_LONG_PRESS_EN enables long-press events inside each channel.
module key_debounce_bank import key_debounce_pkg::*; #(
    parameter int unsigned NumKeys   = 4,
    parameter int unsigned KeyW      = 2,
    parameter int unsigned DebTicks  = 4,
    parameter int unsigned LongTicks = 100
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NumKeys-1:0] key_i,
    input  logic               tick_i,
    output logic               evt_valid_o,
    input  logic               evt_ready_i,
    output logic [KeyW-1:0]    evt_key_o,
    output logic [1:0]         evt_type_o,
    output logic [NumKeys-1:0] key_state_o,
    output logic               overflow_o,
    input  logic               ovf_clr_i
);

    logic [NumKeys-1:0]      pend_valid, drain, drop, grant;
    logic [NumKeys-1:0][1:0] pend_type;
    logic                    found, load;
    logic [KeyW-1:0]         sel_key;
    evt_type_t               sel_type;

    logic            evt_valid_q, evt_valid_d;
    logic [KeyW-1:0] evt_key_q, evt_key_d;
    evt_type_t       evt_type_q, evt_type_d;
    logic            ovf_q, ovf_d;

    for (genvar i = 0; i < NumKeys; i++) begin : g_ch
        key_debounce_ch #(
            .DebTicks  (DebTicks),
            .LongTicks (LongTicks)
        ) u_ch (
            .clk_i        (clk_i),
            .rst_ni       (rst_ni),
            .key_i        (key_i[i]),
            .tick_i       (tick_i),
            .drain_i      (drain[i]),
            .pend_valid_o (pend_valid[i]),
            .pend_type_o  (pend_type[i]),
            .level_o      (key_state_o[i]),
            .drop_o       (drop[i])
        );
    end

    always_comb begin
        grant    = '0;
        found    = 1'b0;
        sel_key  = '0;
        sel_type = EvtPress;
        for (int unsigned i = 0; i < NumKeys; i++) begin
            if (pend_valid[i] && !found) begin
                found    = 1'b1;
                grant[i] = 1'b1;
                sel_key  = KeyW'(i);
                sel_type = pend_type[i];
            end
        end
    end

    assign load  = !evt_valid_q || evt_ready_i;
    assign drain = load ? grant : '0;

    always_comb begin
        evt_valid_d = evt_valid_q;
        evt_key_d   = evt_key_q;
        evt_type_d  = evt_type_q;
        if (load) begin
            evt_valid_d = found;
            if (found) begin
                evt_key_d  = sel_key;
                evt_type_d = sel_type;
            end
        end
        // A fresh drop beats a simultaneous clear.
        ovf_d = ovf_q;
        if (|drop) begin
            ovf_d = 1'b1;
        end else if (ovf_clr_i) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            evt_valid_q <= 1'b0;
            evt_key_q   <= '0;
            evt_type_q  <= EvtPress;
            ovf_q       <= 1'b0;
        end else begin
            evt_valid_q <= evt_valid_d;
            evt_key_q   <= evt_key_d;
            evt_type_q  <= evt_type_d;
            ovf_q       <= ovf_d;
        end
    end

    assign evt_valid_o = evt_valid_q;
    assign evt_key_o   = evt_key_q;
    assign evt_type_o  = evt_type_q;
    assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_key_debounce_bank.sv
// Scoreboard bench for key_debounce_bank: a level/stable-tick model queues expected events,
// a negedge monitor pops them on each handshake and checks debounced levels every cycle.
module tb_key_debounce_bank;
    import key_debounce_pkg::*;

    localparam int unsigned NumKeys   = 4;
    localparam int unsigned KeyW      = 2;
    localparam int unsigned DebTicks  = 4;
    localparam int unsigned LongTicks = 10;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NumKeys-1:0] key_in;
    logic               tick;
    logic               evt_valid;
    logic               evt_ready;
    logic [KeyW-1:0]    evt_key;
    logic [1:0]         evt_type;
    logic [NumKeys-1:0] key_state;
    logic               overflow;
    logic               ovf_clr;

    key_debounce_bank #(
        .NumKeys   (NumKeys),
        .KeyW      (KeyW),
        .DebTicks  (DebTicks),
        .LongTicks (LongTicks)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .key_i       (key_in),
        .tick_i      (tick),
        .evt_valid_o (evt_valid),
        .evt_ready_i (evt_ready),
        .evt_key_o   (evt_key),
        .evt_type_o  (evt_type),
        .key_state_o (key_state),
        .overflow_o  (overflow),
        .ovf_clr_i   (ovf_clr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Tick source: off, every 10 cycles, or random (consecutive ticks possible).
    int tick_mode = 0;
    int cyc = 0;
    always @(posedge clk) begin
        #1;
        cyc++;
        case (tick_mode)
            1:       tick = (cyc % 10 == 0);
            2:       tick = ($urandom_range(5) == 0);
            default: tick = 1'b0;
        endcase
    end

    // Reference model: a level flips after DebTicks ticks on which the synchronized input
    // differed from it, with no intervening cycle where it agreed. Events are key*4+type.
    bit [NumKeys-1:0] m_s1, m_s2, m_lvl;
    int               m_cnt  [NumKeys];
    int               m_long [NumKeys];
    bit               m_fired[NumKeys];
    int               exp_q[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s1 = '0;
            m_s2 = '0;
            m_lvl = '0;
            for (int k = 0; k < NumKeys; k++) begin
                m_cnt[k] = 0;
                m_long[k] = 0;
                m_fired[k] = 1'b0;
            end
            exp_q.delete();
        end else begin
            for (int k = 0; k < NumKeys; k++) begin
                bit s, pressed_now, released_now;
                s = m_s2[k];
                pressed_now = 1'b0;
                released_now = 1'b0;
                if (s == m_lvl[k]) begin
                    m_cnt[k] = 0;
                end else if (tick) begin
                    m_cnt[k]++;
                    if (m_cnt[k] == DebTicks) begin
                        m_lvl[k] = s;
                        m_cnt[k] = 0;
                        exp_q.push_back(k * 4 + (s ? 0 : 1));
                        if (s) begin
                            pressed_now = 1'b1;
                            m_long[k] = 0;
                            m_fired[k] = 1'b0;
                        end else begin
                            released_now = 1'b1;
                        end
                    end
                end
`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
                if (tick && m_lvl[k] && !pressed_now && !released_now && !m_fired[k]) begin
                    m_long[k]++;
                    if (m_long[k] == LongTicks) begin
                        m_fired[k] = 1'b1;
                        exp_q.push_back(k * 4 + 2);
                    end
                end
`else
                if (pressed_now && released_now) m_fired[k] = 1'b0;
`endif
                m_s2[k] = m_s1[k];
                m_s1[k] = key_in[k];
            end
        end
    end

    // Monitor: accepted events pop the oldest expected event of the same key.
    bit              prev_hold = 1'b0;
    logic [KeyW-1:0] prev_key;
    logic [1:0]      prev_type;
    int              acc_log[$];

    always @(negedge clk) begin
        int idx;
        if (rst_n) begin
            check("key_state", key_state, m_lvl);
            if (prev_hold) begin
                check("hold_key", evt_key, prev_key);
                check("hold_type", evt_type, prev_type);
            end
            if (evt_valid && evt_ready) begin
                idx = -1;
                for (int i = 0; i < exp_q.size(); i++) begin
                    if (idx < 0 && exp_q[i] / 4 == int'(evt_key)) idx = i;
                end
                checks++;
                if (idx < 0) begin
                    errors++;
                    $display("FAIL unexpected_event actual key=%0d type=%0d required none",
                             evt_key, evt_type);
                end else begin
                    if (int'(evt_type) != exp_q[idx] % 4) begin
                        errors++;
                        $display("FAIL evt_type key=%0d actual=%0d required=%0d",
                                 evt_key, evt_type, exp_q[idx] % 4);
                    end
                    exp_q.delete(idx);
                end
                acc_log.push_back(int'(evt_key) * 4 + int'(evt_type));
            end
            prev_hold = evt_valid && !evt_ready;
            prev_key  = evt_key;
            prev_type = evt_type;
        end else begin
            prev_hold = 1'b0;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int t = 0;
        while ((exp_q.size() != 0 || evt_valid) && t < budget) begin
            step(1);
            t++;
        end
        check(name, exp_q.size(), 0);
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "_valid"}, evt_valid, 0);
        check({name, "_key"}, evt_key, 0);
        check({name, "_type"}, evt_type, 0);
        check({name, "_state"}, key_state, 0);
        check({name, "_ovf"}, overflow, 0);
    endtask

    initial begin
        int t, n;
        rst_n = 1'b0;
        key_in = '0;
        evt_ready = 1'b0;
        ovf_clr = 1'b0;
        tick = 1'b0;
        step(3);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        step(2);
        tick_mode = 1;

        // Single press/release on key 2.
        evt_ready = 1'b1;
        acc_log.delete();
        key_in[2] = 1'b1;
        step(60);
        check("t1_level", key_state[2], 1);
        key_in[2] = 1'b0;
        step(80);
        wait_drain("t1_drain", 200);
        check("t1_count", acc_log.size(), 2);
        if (acc_log.size() == 2) begin
            check("t1_press", acc_log[0], 2 * 4 + 0);
            check("t1_release", acc_log[1], 2 * 4 + 1);
        end

        // Bouncing key 0 never stays stable for DebTicks ticks.
        acc_log.delete();
        repeat (14) begin
            key_in[0] = ~key_in[0];
            step(15);
        end
        key_in[0] = 1'b0;
        step(30);
        check("t2_events", acc_log.size(), 0);
        check("t2_state", key_state, 0);

        // Simultaneous presses under backpressure: lowest index first and held stable.
        evt_ready = 1'b0;
        acc_log.delete();
        key_in[1] = 1'b1;
        key_in[3] = 1'b1;
        t = 0;
        while (!evt_valid && t < 100) begin
            step(1);
            t++;
        end
        check("t3_valid", evt_valid, 1);
        repeat (50) begin
            step(1);
            check("t3_held", {evt_valid, evt_key, evt_type}, {1'b1, 2'd1, 2'd0});
        end
        evt_ready = 1'b1;
        wait_drain("t3_drain", 50);
        check("t3_count", acc_log.size(), 2);
        if (acc_log.size() == 2) begin
            check("t3_first", acc_log[0], 1 * 4 + 0);
            check("t3_second", acc_log[1], 3 * 4 + 0);
        end
        key_in = '0;
        step(80);
        wait_drain("t3_rel_drain", 100);

        // Overflow: output register and slot both full, then a third event arrives.
        evt_ready = 1'b0;
        acc_log.delete();
        key_in[0] = 1'b1;
        step(80);
        key_in[0] = 1'b0;
        step(80);
        check("t4_no_ovf", overflow, 0);
        key_in[0] = 1'b1;
        step(80);
        check("t4_ovf", overflow, 1);
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i] / 4 == 0) begin
                exp_q.delete(i);
                break;
            end
        end
        ovf_clr = 1'b1;
        step(1);
        ovf_clr = 1'b0;
        check("t4_ovf_clr", overflow, 0);
        evt_ready = 1'b1;
        wait_drain("t4_drain", 50);
        check("t4_count", acc_log.size(), 2);
        if (acc_log.size() == 2) begin
            check("t4_press", acc_log[0], 0);
            check("t4_release", acc_log[1], 1);
        end
        key_in[0] = 1'b0;
        step(80);
        wait_drain("t4_rel_drain", 100);

        // Long hold of key 1.
        acc_log.delete();
        key_in[1] = 1'b1;
        step(250);
        key_in[1] = 1'b0;
        step(80);
        wait_drain("t5_drain", 100);
`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
        check("t5_count", acc_log.size(), 3);
        if (acc_log.size() == 3) begin
            check("t5_press", acc_log[0], 1 * 4 + 0);
            check("t5_long", acc_log[1], 1 * 4 + 2);
            check("t5_release", acc_log[2], 1 * 4 + 1);
        end
`else
        check("t5_count", acc_log.size(), 2);
        if (acc_log.size() == 2) begin
            check("t5_press", acc_log[0], 1 * 4 + 0);
            check("t5_release", acc_log[1], 1 * 4 + 1);
        end
`endif

        // Reset in the middle of a held event and a pending press.
        evt_ready = 1'b0;
        key_in[3] = 1'b1;
        step(60);
        key_in[2] = 1'b1;
        step(25);
        check("t6_valid_before", evt_valid, 1);
        check("t6_pend_level", key_state[2], 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("t6_reset");
        step(2);
        rst_n = 1'b1;
        n = 0;
        t = 0;
        while (!key_state[2] && t < 200) begin
            if (tick) n++;
            step(1);
            t++;
        end
        check("t6_rearmed", key_state[2], 1);
        check("t6_window", (n >= DebTicks && n <= DebTicks + 1), 1);
        evt_ready = 1'b1;
        wait_drain("t6_drain", 50);
        key_in = '0;
        step(80);
        wait_drain("t6_rel_drain", 100);

        // Randomized key activity, ready and tick pattern.
        tick_mode = 2;
        begin
            int hold[NumKeys];
            for (int k = 0; k < NumKeys; k++) hold[k] = $urandom_range(60, 1);
            repeat (3000) begin
                for (int k = 0; k < NumKeys; k++) begin
                    hold[k]--;
                    if (hold[k] <= 0) begin
                        key_in[k] = ~key_in[k];
                        hold[k] = ($urandom_range(1) == 0) ? $urandom_range(12, 1)
                                                           : $urandom_range(120, 20);
                    end
                end
                evt_ready = ($urandom_range(3) != 0);
                step(1);
            end
        end
        key_in = '0;
        evt_ready = 1'b1;
        tick_mode = 1;
        step(100);
        wait_drain("rand_drain", 200);
        check("rand_ovf", overflow, 0);
        check("rand_state", key_state, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_debounce_bank.md
Name: key_debounce_bank

Overview:
- Downstream consumer of the timer block: its one-cycle `done` strobe drives this block's `tick` input as the debounce sample clock-enable.
- Debounces NUM_KEYS raw front-panel key inputs for the control-board screen.
- Arbitrates press/release/long-press events into a single valid/ready event stream read by the screen controller.
- Also exports the debounced key levels.

Parameters:
- NUM_KEYS, 4: number of key channels (1..16).
- KEY_W, 2: event key-index width; must satisfy 2**KEY_W >= NUM_KEYS.
- DEB_TICKS, 4: consecutive ticks of stable input needed to accept a level change (1..255).
- LONG_TICKS, 100: ticks held in PRESSED before a long-press event (1..255; used only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- key_in  in  NUM_KEYS  raw key levels, 1 = pressed; asynchronous to clk.
- tick  in  1  sample strobe, normally timer `done`; may be high on consecutive cycles.
- evt_valid  out  1  event output holds a valid event.
- evt_ready  in  1  consumer accepts the event when evt_valid && evt_ready.
- evt_key  out  KEY_W  index of the channel that produced the event.
- evt_type  out  2  00 press, 01 release, 10 long press, 11 reserved (never driven).
- key_state  out  NUM_KEYS  debounced levels.
- overflow  out  1  sticky: an event was dropped.
- ovf_clr  in  1  clears overflow.

Behaviour:
- Reset (rst low, async): all synchronizers, counters and pending flags cleared; every channel FSM goes to RELEASED. Output reset values: evt_valid=0, evt_key=0, evt_type=00, key_state=0, overflow=0. Reset asserted mid-handshake discards the held event.
- Synchronizer: two-flop per key, clocked every cycle regardless of tick; the FSM sees only the synchronized level `s`.
- Channel FSM; `cnt` is 8-bit and advances only on cycles with tick=1.
  - RELEASED: on tick with s=1, cnt<=1 and go to PRESS_PEND. If DEB_TICKS==1, go directly to PRESSED and raise a press event.
  - PRESS_PEND: on any cycle with s=0, return to RELEASED with cnt<=0; no tick is needed. On tick with s=1: if cnt==DEB_TICKS-1, go to PRESSED and raise a press event; otherwise cnt+1.
  - PRESSED: mirror of RELEASED toward RELEASE_PEND with s=0.
  - RELEASE_PEND: mirror of PRESS_PEND; completes to RELEASED and raises a release event.
- key_state[i] = 1 in PRESSED and RELEASE_PEND; updates in the same cycle the FSM state register updates.
- Pending slot, one per channel, holding a valid flag and a type:
  - Raising an event while the slot is empty fills the slot.
  - Raising an event while the slot is full and not being drained this cycle drops the new event and sets overflow.
  - If the slot is drained and refilled in the same cycle, the new event is kept.
- Output register:
  - Loads when evt_valid==0, or when evt_valid && evt_ready.
  - Takes the lowest-index channel with a pending slot and clears that slot in the same cycle.
  - If no slot is pending at load time, evt_valid goes to 0.
- Latency: an event raised at edge N appears with evt_valid=1 at edge N+1 at the earliest.
- Hold rule: evt_key and evt_type are stable while evt_valid && !evt_ready.
- Overflow: if ovf_clr and a new drop occur in the same cycle, the set wins.

Optional Feature:
- Macro: KEY_DEBOUNCE_LONG_PRESS_EN.
- Defined:
  - Each channel has an 8-bit long counter, cleared on entry to PRESSED, incremented on tick while in PRESSED or RELEASE_PEND, saturating.
  - When it reaches LONG_TICKS, the channel raises evt_type=10 exactly once per press.
  - Release still produces 01 afterwards.
- Undefined: no long counter logic is generated and 10 is never emitted.

Decomposition:
- Shared package/header key_debounce_pkg:
  - event-type constants EVT_PRESS=2'b00, EVT_RELEASE=2'b01, EVT_LONG=2'b10;
  - FSM state encodings ST_RELEASED, ST_PRESS_PEND, ST_PRESSED, ST_RELEASE_PEND.
- Sub-module key_debounce_ch: synchronizer, FSM, counters and pending slot for one key. It is instantiated NUM_KEYS times via generate.
- The top level holds the priority arbiter, output register and overflow flag.

Test Plan:
- Press/release: DEB_TICKS=4, tick every 10 cycles. Hold key 2 high for 60 cycles, then low -> one event {2,00}, key_state[2]=1, then one event {2,01}; evt_ready held 1.
- Bounce: key 0 toggles every 15 cycles (tick every 10) for 200 cycles -> no events, key_state=0.
- Backpressure/arbitration: keys 1 and 3 press on the same tick while evt_ready=0 for 50 cycles -> evt_valid stays 1 with {1,00} stable. Raise evt_ready -> {1,00} accepted, then {3,00}.
- Overflow: evt_ready=0; key 0 completes a press then a release -> first event held, release held in the slot. A second press completing while both are full -> overflow=1; ovf_clr pulse -> 0.
- Long press (macro defined, LONG_TICKS=10): hold key 1 for 20 ticks -> {1,00}, then {1,10} exactly once, then {1,01} on release. With the macro undefined -> no 10 event.
- Reset mid-operation: assert rst while evt_valid=1 and key 2 in PRESS_PEND -> all outputs 0 immediately. After release of rst with key 2 still high, a fresh full DEB_TICKS window is needed before press.
